tag_alloc_sched: RTL and testbench
==================================

TAG_ALLOC_SCHED -- requirements
Module: tag_alloc_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of AR requesters sharing the tag allocator (power of two, >=2).
REQ-002 SHALL have parameter ID_WIDTH, default 4: original AXI ID width.
REQ-003 SHALL have parameter UID_W, default 6: allocator unique-ID width.
REQ-004 SHALL have parameter FREE_DEPTH, default 4: release FIFO depth (power of two).
REQ-005 SHALL have parameter STALL_THRESH, default 16: retry cycles before stall flag.
REQ-006 SHALL have parameter MAX_OUTSTANDING, default 16: bound for outstanding counter.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 req_valid  input  NUM_REQ  per-requester allocation request.
REQ-010 req_id  input  NUM_REQ*ID_WIDTH  per-requester original ID, slice i = bits [i*ID_WIDTH +: ID_WIDTH].
REQ-011 req_ready  output  NUM_REQ  one-hot grant pulse to winning requester.
REQ-012 grant_uid  output  UID_W  unique ID delivered with req_ready.
REQ-013 alloc_req  output  1  request to allocator.
REQ-014 alloc_id  output  ID_WIDTH  ID presented to allocator.
REQ-015 alloc_gnt  input  1  allocator accepted alloc_req this cycle.
REQ-016 alloc_uid  input  UID_W  allocator unique ID, valid with alloc_gnt.
REQ-017 rel_valid  input  1  release request from response path.
REQ-018 rel_uid  input  UID_W  unique ID to release.
REQ-019 rel_ready  output  1  release FIFO can accept.
REQ-020 free_req  output  1  free command to allocator.
REQ-021 free_uid  output  UID_W  unique ID to free.
REQ-022 outstanding  output  clog2(MAX_OUTSTANDING+1)  granted-but-not-freed count.
REQ-023 alloc_stall  output  1  allocation retrying for >= STALL_THRESH cycles.

Function
REQ-024 Alloc FSM SHALL have states IDLE and ISSUE.
REQ-025 IDLE: if any req_valid, SHALL select winner round-robin starting at rr_ptr, latch index and req_id, go ISSUE next cycle; else stay.
REQ-026 ISSUE: alloc_req SHALL be 1 and alloc_id SHALL equal latched ID; in IDLE alloc_req=0, alloc_id=0.
REQ-027 ISSUE with alloc_gnt=1: req_ready[latched idx]=1 and grant_uid=alloc_uid combinationally that cycle; rr_ptr <= (idx+1) mod NUM_REQ; go IDLE.
REQ-028 ISSUE with alloc_gnt=0: stay ISSUE, keep latched winner (no re-arbitration), retry_cnt += 1 saturating at 255.
REQ-029 retry_cnt SHALL clear on grant and in IDLE; alloc_stall = (retry_cnt >= STALL_THRESH).
REQ-030 Requesters SHALL hold req_valid and req_id stable until req_ready; minimum grant latency is 1 cycle after req_valid.
REQ-031 req_ready SHALL be 0 for all bits except the single cycle in REQ-027; grant_uid=0 when no req_ready.
REQ-032 Release FIFO: push when rel_valid && rel_ready; rel_ready = !full (no pass-through when full).
REQ-033 free_req = !empty, free_uid = FIFO head; head pops every cycle free_req=1 (allocator accepts unconditionally).
REQ-034 FIFO empty with rel_valid: entry appears on free_req next cycle (1-cycle latency).
REQ-035 FIFO pointers SHALL wrap modulo FREE_DEPTH with an extra wrap bit for full/empty.
REQ-036 Simultaneous push and pop SHALL preserve occupancy; push when full SHALL be impossible (rel_ready=0).
REQ-037 outstanding SHALL +1 on grant, -1 on free_req, unchanged when both; saturate at MAX_OUTSTANDING and 0.
REQ-038 free_req and alloc_req SHALL be allowed in the same cycle.

Reset
REQ-039 On rst: FSM=IDLE, rr_ptr=0, retry_cnt=0, FIFO empty, outstanding=0.
REQ-040 During/after rst cycle: req_ready=0, grant_uid=0, alloc_req=0, alloc_id=0, free_req=0, free_uid=0, rel_ready=1 after reset, alloc_stall=0.
REQ-041 rst asserted in ISSUE SHALL abandon the latched request; no req_ready issued for it.

Verification
REQ-042 req_valid=4'b1111 held, alloc_gnt=1 always -> req_ready pulses order 0,1,2,3,0 one grant every 2 cycles.
REQ-043 req_valid[2]=1, id=5, alloc_gnt=0 for 20 cycles then 1 with alloc_uid=0x09 -> alloc_id=5 throughout, alloc_stall=1 from 16th retry, req_ready[2]=1 with grant_uid=0x09, alloc_stall=0 next cycle.
REQ-044 Push 5 rel_uid values 1..5 back-to-back with free side starved impossible -> verify FIFO drains in order 1..5 on free_req, rel_ready never 0 since pop each cycle.
REQ-045 Grant and free_req same cycle with outstanding=3 -> outstanding stays 3; grant alone -> 4.
REQ-046 rst asserted while in ISSUE with alloc_gnt=0 -> next cycle alloc_req=0, req_ready=0, outstanding=0, rr_ptr=0.

Source files
------------

// File: rtl/tag_alloc_sched.sv
// Round-robin front end for a shared AXI tag allocator: arbitrates AR requesters,
// retries the allocator until granted, and queues tag releases into a small free FIFO.
module tag_alloc_sched #(
    parameter int NUM_REQ         = 4,
    parameter int ID_WIDTH        = 4,
    parameter int UID_W           = 6,
    parameter int FREE_DEPTH      = 4,
    parameter int STALL_THRESH    = 16,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_REQ-1:0]                     req_valid,
    input  logic [NUM_REQ*ID_WIDTH-1:0]            req_id,
    output logic [NUM_REQ-1:0]                     req_ready,
    output logic [UID_W-1:0]                       grant_uid,
    output logic                                   alloc_req,
    output logic [ID_WIDTH-1:0]                    alloc_id,
    input  logic                                   alloc_gnt,
    input  logic [UID_W-1:0]                       alloc_uid,
    input  logic                                   rel_valid,
    input  logic [UID_W-1:0]                       rel_uid,
    output logic                                   rel_ready,
    output logic                                   free_req,
    output logic [UID_W-1:0]                       free_uid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   alloc_stall
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(FREE_DEPTH);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [7:0]       STALL_T = 8'(STALL_THRESH);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t               state, state_nxt;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     win_idx;
    logic [ID_WIDTH-1:0]  win_id;
    logic [7:0]           retry_cnt;

    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     cand;
    logic                 grant;

    // Descending scan so the candidate closest to rr_ptr is the last one written.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = rr_ptr + IDX_W'(k);
            if (req_valid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        unique case (state)
            IDLE:  if (pick_valid) state_nxt = ISSUE;
            ISSUE: begin
                if (alloc_gnt) begin
                    grant     = !rst;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            win_idx   <= '0;
            win_id    <= '0;
            retry_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && pick_valid) begin
                win_idx <= pick_idx;
                win_id  <= req_id[pick_idx*ID_WIDTH +: ID_WIDTH];
            end
            if (grant) begin
                rr_ptr <= win_idx + IDX_W'(1);
            end
            if (state == ISSUE && !alloc_gnt) begin
                retry_cnt <= (retry_cnt == 8'hFF) ? retry_cnt : retry_cnt + 8'd1;
            end else begin
                retry_cnt <= '0;
            end
        end
    end

    // Outputs are forced idle while rst is high so an abandoned request never handshakes.
    assign alloc_req   = (state == ISSUE) && !rst;
    assign alloc_id    = alloc_req ? win_id : '0;
    assign req_ready   = grant ? (NUM_REQ'(1) << win_idx) : '0;
    assign grant_uid   = grant ? alloc_uid : '0;
    assign alloc_stall = !rst && (retry_cnt >= STALL_T);

    logic [UID_W-1:0] mem [FREE_DEPTH];
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic             empty, full, push;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                       (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign rel_ready = !rst && !full;
    assign push      = rel_valid && rel_ready;
    assign free_req  = !rst && !empty;
    assign free_uid  = free_req ? mem[rd_ptr[PTR_W-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)     wr_ptr <= wr_ptr + 1'b1;
            if (free_req) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-1:0]] <= rel_uid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (grant && !free_req) begin
            if (outstanding != OUT_MAX) outstanding <= outstanding + 1'b1;
        end else if (free_req && !grant) begin
            if (outstanding != '0) outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_tag_alloc_sched.sv
// Directed bench for tag_alloc_sched: round-robin order, retry/stall, release FIFO
// ordering, outstanding accounting and reset during an in-flight request.
module tb_tag_alloc_sched;

    localparam int NUM_REQ  = 4;
    localparam int ID_WIDTH = 4;
    localparam int UID_W    = 6;
    localparam int OUT_W    = 5;

    logic                         clk = 1'b0;
    logic                         rst;
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ*ID_WIDTH-1:0]  req_id;
    logic [NUM_REQ-1:0]           req_ready;
    logic [UID_W-1:0]             grant_uid;
    logic                         alloc_req;
    logic [ID_WIDTH-1:0]          alloc_id;
    logic                         alloc_gnt;
    logic [UID_W-1:0]             alloc_uid;
    logic                         rel_valid;
    logic [UID_W-1:0]             rel_uid;
    logic                         rel_ready;
    logic                         free_req;
    logic [UID_W-1:0]             free_uid;
    logic [OUT_W-1:0]             outstanding;
    logic                         alloc_stall;

    logic [ID_WIDTH-1:0] ids [NUM_REQ] = '{4'hA, 4'h7, 4'hC, 4'h3};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tag_alloc_sched #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH), .UID_W(UID_W),
        .FREE_DEPTH(4), .STALL_THRESH(16), .MAX_OUTSTANDING(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_id(req_id), .req_ready(req_ready), .grant_uid(grant_uid),
        .alloc_req(alloc_req), .alloc_id(alloc_id), .alloc_gnt(alloc_gnt), .alloc_uid(alloc_uid),
        .rel_valid(rel_valid), .rel_uid(rel_uid), .rel_ready(rel_ready),
        .free_req(free_req), .free_uid(free_uid),
        .outstanding(outstanding), .alloc_stall(alloc_stall)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One grant to requester idx; optionally pushes a release the cycle before so
    // the free pops in the same cycle as the grant.
    task automatic grant_once(input int idx, input logic [UID_W-1:0] uid, input bit with_free);
        req_valid = 4'(1 << idx);
        alloc_gnt = 1'b1;
        alloc_uid = uid;
        rel_valid = with_free;
        rel_uid   = 6'h2A;
        #1;
        check("g_idle_ready", 32'(req_ready), 32'h0);
        step();
        rel_valid = 1'b0;
        #1;
        check("g_ready", 32'(req_ready), 32'(1 << idx));
        check("g_uid", 32'(grant_uid), 32'(uid));
        check("g_free_req", 32'(free_req), 32'(with_free));
        if (with_free) check("g_free_uid", 32'(free_uid), 32'h2A);
        step();
        req_valid = '0;
        alloc_gnt = 1'b0;
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_id    = '0;
        alloc_gnt = 1'b0;
        alloc_uid = '0;
        rel_valid = 1'b0;
        rel_uid   = '0;

        step();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_alloc_req", 32'(alloc_req), 32'h0);
        check("rst_alloc_id", 32'(alloc_id), 32'h0);
        check("rst_grant_uid", 32'(grant_uid), 32'h0);
        check("rst_free_req", 32'(free_req), 32'h0);
        check("rst_free_uid", 32'(free_uid), 32'h0);
        check("rst_stall", 32'(alloc_stall), 32'h0);
        step();
        rst = 1'b0;
        #1;
        check("post_rst_rel_ready", 32'(rel_ready), 32'h1);
        check("post_rst_outstanding", 32'(outstanding), 32'h0);
        check("post_rst_alloc_req", 32'(alloc_req), 32'h0);

        // All four requesting, allocator always grants: 0,1,2,3,0 every other cycle.
        req_id    = {ids[3], ids[2], ids[1], ids[0]};
        req_valid = 4'hF;
        alloc_gnt = 1'b1;
        for (int i = 0; i < 10; i++) begin
            alloc_uid = 6'(8 + i);
            #1;
            if (i % 2 == 1) begin
                check("rr_ready", 32'(req_ready), 32'(1 << ((i / 2) % 4)));
                check("rr_uid", 32'(grant_uid), 32'(8 + i));
                check("rr_alloc_id", 32'(alloc_id), 32'(ids[(i / 2) % 4]));
            end else begin
                check("rr_idle_ready", 32'(req_ready), 32'h0);
                check("rr_idle_alloc_req", 32'(alloc_req), 32'h0);
            end
            step();
        end
        req_valid = '0;
        alloc_gnt = 1'b0;
        #1;
        check("rr_outstanding", 32'(outstanding), 32'd5);

        // Requester 2 alone, allocator refuses 20 cycles then grants uid 0x09.
        req_valid = 4'b0100;
        req_id    = {4'h0, 4'h5, 4'h0, 4'h0};
        alloc_uid = '0;
        #1;
        check("st_idle_alloc_req", 32'(alloc_req), 32'h0);
        step();
        for (int j = 0; j < 20; j++) begin
            check("st_alloc_req", 32'(alloc_req), 32'h1);
            check("st_alloc_id", 32'(alloc_id), 32'h5);
            check("st_ready", 32'(req_ready), 32'h0);
            check("st_stall", 32'(alloc_stall), 32'(j >= 16));
            step();
        end
        alloc_gnt = 1'b1;
        alloc_uid = 6'h09;
        #1;
        check("st_grant_ready", 32'(req_ready), 32'b0100);
        check("st_grant_uid", 32'(grant_uid), 32'h09);
        check("st_grant_alloc_id", 32'(alloc_id), 32'h5);
        step();
        req_valid = '0;
        alloc_gnt = 1'b0;
        alloc_uid = '0;
        #1;
        check("st_stall_clear", 32'(alloc_stall), 32'h0);
        check("st_after_ready", 32'(req_ready), 32'h0);
        check("st_outstanding", 32'(outstanding), 32'd6);

        // Release FIFO: 1..5 back-to-back, each appears on free side one cycle later.
        for (int k = 1; k <= 5; k++) begin
            rel_valid = 1'b1;
            rel_uid   = 6'(k);
            #1;
            check("fifo_rel_ready", 32'(rel_ready), 32'h1);
            check("fifo_free_req", 32'(free_req), 32'(k > 1));
            if (k > 1) check("fifo_free_uid", 32'(free_uid), 32'(k - 1));
            step();
        end
        rel_valid = 1'b0;
        #1;
        check("fifo_last_free_req", 32'(free_req), 32'h1);
        check("fifo_last_free_uid", 32'(free_uid), 32'h5);
        step();
        check("fifo_empty_free_req", 32'(free_req), 32'h0);
        check("fifo_outstanding", 32'(outstanding), 32'd1);

        // Outstanding: bring to 3, then grant+free together, then grant alone.
        grant_once(0, 6'h01, 1'b0);
        grant_once(0, 6'h02, 1'b0);
        check("os_three", 32'(outstanding), 32'd3);
        grant_once(0, 6'h03, 1'b1);
        check("os_grant_and_free", 32'(outstanding), 32'd3);
        grant_once(0, 6'h04, 1'b0);
        check("os_grant_alone", 32'(outstanding), 32'd4);

        // Reset while ISSUE is retrying: request dropped, counters and rr_ptr cleared.
        req_valid = 4'b0010;
        #1;
        step();
        check("rs_issue_alloc_req", 32'(alloc_req), 32'h1);
        rst = 1'b1;
        #1;
        check("rs_during_alloc_req", 32'(alloc_req), 32'h0);
        check("rs_during_ready", 32'(req_ready), 32'h0);
        step();
        rst       = 1'b0;
        req_valid = '0;
        #1;
        check("rs_after_alloc_req", 32'(alloc_req), 32'h0);
        check("rs_after_ready", 32'(req_ready), 32'h0);
        check("rs_after_outstanding", 32'(outstanding), 32'h0);
        check("rs_after_stall", 32'(alloc_stall), 32'h0);

        // rr_ptr was 1 before reset; after reset requester 0 must win.
        req_valid = 4'hF;
        req_id    = {ids[3], ids[2], ids[1], ids[0]};
        alloc_gnt = 1'b1;
        alloc_uid = 6'h11;
        #1;
        step();
        check("rs_rr_ready", 32'(req_ready), 32'b0001);
        check("rs_rr_uid", 32'(grant_uid), 32'h11);
        step();
        req_valid = '0;
        alloc_gnt = 1'b0;
        #1;
        check("rs_rr_outstanding", 32'(outstanding), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
